ysyx_25060170_stage_ctrl: RTL
=============================

// Module: ysyx_25060170_stage_ctrl
// PURPOSE
//  Multi-cycle sequencer for the single-issue core. Drives IFU, IDU, EXU, LSU and GPR one stage
//  at a time over valid/ready handshakes, so exactly one instruction is in flight.
//  Generates the PC-update and GPR write strobes and counts retired instructions.
//  Stops on ebreak (HALT) or on a hung stage (ERR, via watchdog).
// PARAMETERS
//  CNT_W    32   width of retired-instruction counter
//  TO_W     8    width of watchdog counter
//  TIMEOUT  255  max wait cycles per stage before ERR; 0 disables the watchdog
// PORTS
//  clk          in   1      core clock
//  rst          in   1      asynchronous reset, active-high
//  ifu_valid_o  out  1      fetch request to IFU
//  ifu_ready_i  in   1      IFU has instruction word
//  idu_valid_o  out  1      decode request to IDU
//  idu_ready_i  in   1      IDU decode fields stable
//  is_load_i    in   1      decoded load; sampled on IDU handshake
//  is_store_i   in   1      decoded store; sampled on IDU handshake
//  reg_we_i     in   1      decoded RegW; sampled on IDU handshake
//  halt_i       in   1      decoded ebreak; sampled on IDU handshake
//  exu_valid_o  out  1      execute request to EXU
//  exu_ready_i  in   1      EXU result valid
//  lsu_valid_o  out  1      data-memory request to MEM
//  lsu_ready_i  in   1      MEM access complete
//  gpr_we_o     out  1      one-cycle GPR write strobe
//  pc_we_o      out  1      one-cycle PC update strobe to IFU
//  halted_o     out  1      sticky: ebreak retired
//  err_o        out  1      sticky: watchdog expired or illegal decode
//  state_o      out  3      current state, debug
//  inst_cnt_o   out  CNT_W  retired instructions, wraps to 0
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, all outputs 0, latched decode bits 0, counters 0.
//  States: IDLE->IF->ID->EX->(LS)->WB->IF; terminal HALT, ERR (left only by rst).
//   IDLE: one cycle after rst deassert, then IF.
//   IF/ID/EX/LS: the stage's valid_o is 1 while in the state (Moore, registered). A handshake is
//    valid_o&&ready_i in the same cycle; state advances on that edge and valid_o is 0 the next cycle.
//    A ready_i arriving while valid_o is 0 is ignored.
//   ID handshake latches is_load/is_store/reg_we/halt. load&&store both 1 -> ERR.
//   EX exit: to LS if latched load|store, else to WB.
//   WB: single cycle; pc_we_o=1; gpr_we_o=latched reg_we (forced 0 for a store);
//    inst_cnt_o+=1 (wraps modulo 2^CNT_W). Next state is HALT if latched halt, else IF.
//   HALT: halted_o=1, all valids/strobes 0. ERR: err_o=1, all valids/strobes 0.
//  Latency with zero-wait readies: ALU op 4 cycles IF->IF; load/store 5 cycles.
//  Watchdog: cleared on every state entry; counts each cycle valid_o&&!ready_i;
//   reaching TIMEOUT (TIMEOUT!=0) -> ERR next edge. A handshake in that same cycle wins.
//  Reset mid-stage: valids drop asynchronously; no WB strobe is emitted for the aborted instruction.
// STRUCTURE
//  ysyx_25060170_pkg: state localparams (IDLE=0,IF=1,ID=2,EX=3,LS=4,WB=5,HALT=6,ERR=7), STATE_W=3.
//  Sub-module ysyx_25060170_wdt: clear/enable/expire counter, params TO_W, TIMEOUT.
//  Top: next-state logic, registered outputs, decode latches, retire counter.
// TESTING
//  1 All readies tied 1, decode ALU op reg_we=1: pc_we_o every 4 cycles, gpr_we_o with each;
//    inst_cnt_o=3 after 12 cycles from IF entry.
//  2 Load, lsu_ready_i delayed 3 cycles: lsu_valid_o high 4 cycles, WB on the 5th.
//    Store: gpr_we_o=0 even with reg_we_i=1.
//  3 halt_i=1 at ID: the instruction retires (inst_cnt_o+1), then halted_o=1 and state_o=6;
//    valids stay 0 for 100 cycles.
//  4 TIMEOUT=4, exu_ready_i held 0: err_o=1 after 4 wait cycles; ready at cycle 4 -> no ERR.
//    is_load_i&&is_store_i at ID -> ERR.
//  5 rst asserted mid-LS: lsu_valid_o falls without a clock edge; after release,
//    IDLE 1 cycle then ifu_valid_o=1; inst_cnt_o=0.
//  6 CNT_W=4, 17 retirements: inst_cnt_o wraps to 1.

Source files
------------

// File: rtl/ysyx_25060170_pkg.sv
// Shared types for the multi-cycle stage sequencer: state encoding, stage
// indices for the valid/ready vectors and the latched decode bundle.
package ysyx_25060170_pkg;

    localparam int STATE_W = 3;
    localparam int N_STAGE = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_IF   = 3'd1,
        ST_ID   = 3'd2,
        ST_EX   = 3'd3,
        ST_LS   = 3'd4,
        ST_WB   = 3'd5,
        ST_HALT = 3'd6,
        ST_ERR  = 3'd7
    } state_t;

    // Bit positions of each handshaking stage inside the valid/ready vectors.
    localparam int STG_IF = 0;
    localparam int STG_ID = 1;
    localparam int STG_EX = 2;
    localparam int STG_LS = 3;

    typedef struct packed {
        logic is_load;
        logic is_store;
        logic reg_we;
        logic halt;
    } decode_t;

    function automatic state_t stage_state(input int idx);
        state_t s;
        case (idx)
            STG_IF:  s = ST_IF;
            STG_ID:  s = ST_ID;
            STG_EX:  s = ST_EX;
            default: s = ST_LS;
        endcase
        return s;
    endfunction

    function automatic logic is_mem_op(input decode_t d);
        return d.is_load | d.is_store;
    endfunction

endpackage

// File: rtl/ysyx_25060170_stage_ctrl_if.sv
// Valid/ready handshakes between the sequencer and the IFU/IDU/EXU/LSU stages,
// plus the decode fields the sequencer samples at the IDU handshake.
interface ysyx_25060170_stage_ctrl_if;

    logic ifu_valid_o;
    logic ifu_ready_i;
    logic idu_valid_o;
    logic idu_ready_i;
    logic is_load_i;
    logic is_store_i;
    logic reg_we_i;
    logic halt_i;
    logic exu_valid_o;
    logic exu_ready_i;
    logic lsu_valid_o;
    logic lsu_ready_i;

    modport master (
        output ifu_valid_o,
        output idu_valid_o,
        output exu_valid_o,
        output lsu_valid_o,
        input  ifu_ready_i,
        input  idu_ready_i,
        input  exu_ready_i,
        input  lsu_ready_i,
        input  is_load_i,
        input  is_store_i,
        input  reg_we_i,
        input  halt_i
    );

    modport slave (
        input  ifu_valid_o,
        input  idu_valid_o,
        input  exu_valid_o,
        input  lsu_valid_o,
        output ifu_ready_i,
        output idu_ready_i,
        output exu_ready_i,
        output lsu_ready_i,
        output is_load_i,
        output is_store_i,
        output reg_we_i,
        output halt_i
    );

endinterface

// File: rtl/ysyx_25060170_wdt.sv
// Per-stage watchdog: counts stalled cycles, saturates at TIMEOUT and flags
// expiry while saturated. TIMEOUT of 0 disables expiry entirely.
module ysyx_25060170_wdt #(
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TO_W-1:0] LIMIT   = TO_W'(TIMEOUT);
    localparam bit              ENABLED = (TIMEOUT != 0);

    logic [TO_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en && (cnt_reg != LIMIT)) begin
            cnt_reg <= cnt_reg + TO_W'(1);
        end
    end

    assign expired = ENABLED && (cnt_reg == LIMIT);

endmodule

// File: rtl/ysyx_25060170_stage_ctrl.sv
// Multi-cycle sequencer: walks one instruction through IF/ID/EX/(LS)/WB,
// emits the PC/GPR write strobes and counts retirements; stops on HALT or ERR.
module ysyx_25060170_stage_ctrl
    import ysyx_25060170_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    ysyx_25060170_stage_ctrl_if.master bus,
    output logic                       gpr_we_o,
    output logic                       pc_we_o,
    output logic                       halted_o,
    output logic                       err_o,
    output logic [STATE_W-1:0]         state_o,
    output logic [CNT_W-1:0]           inst_cnt_o
);

    state_t             state_reg;
    state_t             state_next;
    logic [N_STAGE-1:0] valid_reg;
    logic [N_STAGE-1:0] valid_next;
    logic [N_STAGE-1:0] ready_vec;
    decode_t            dec_reg;
    decode_t            dec_in;
    logic               pc_we_reg;
    logic               gpr_we_reg;
    logic               halted_reg;
    logic               err_reg;
    logic [CNT_W-1:0]   inst_cnt_reg;
    logic               stage_busy;
    logic               handshake;
    logic               illegal_dec;
    logic               wdt_clr;
    logic               wdt_en;
    logic               wdt_expired;

    assign ready_vec = {bus.lsu_ready_i, bus.exu_ready_i, bus.idu_ready_i, bus.ifu_ready_i};

    // Only the registered valid qualifies a ready, so early readies are ignored.
    assign stage_busy = |valid_reg;
    assign handshake  = |(valid_reg & ready_vec);

    assign dec_in      = '{is_load:  bus.is_load_i,
                           is_store: bus.is_store_i,
                           reg_we:   bus.reg_we_i,
                           halt:     bus.halt_i};
    assign illegal_dec = dec_in.is_load && dec_in.is_store;

    assign wdt_en  = stage_busy && !handshake;
    assign wdt_clr = (state_next != state_reg);

    ysyx_25060170_wdt #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_wdt (
        .clk     (clk),
        .rst     (rst),
        .clr     (wdt_clr),
        .en      (wdt_en),
        .expired (wdt_expired)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: state_next = ST_IF;
            ST_IF: begin
                if (handshake)        state_next = ST_ID;
                else if (wdt_expired) state_next = ST_ERR;
            end
            ST_ID: begin
                if (handshake)        state_next = illegal_dec ? ST_ERR : ST_EX;
                else if (wdt_expired) state_next = ST_ERR;
            end
            ST_EX: begin
                if (handshake)        state_next = is_mem_op(dec_reg) ? ST_LS : ST_WB;
                else if (wdt_expired) state_next = ST_ERR;
            end
            ST_LS: begin
                if (handshake)        state_next = ST_WB;
                else if (wdt_expired) state_next = ST_ERR;
            end
            ST_WB:   state_next = dec_reg.halt ? ST_HALT : ST_IF;
            ST_HALT: state_next = ST_HALT;
            ST_ERR:  state_next = ST_ERR;
            default: state_next = ST_ERR;
        endcase
    end

    // Outputs are registered from the next state so they are glitch-free Moore signals.
    for (genvar gi = 0; gi < N_STAGE; gi++) begin : g_valid
        assign valid_next[gi] = (state_next == stage_state(gi));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            valid_reg    <= '0;
            pc_we_reg    <= 1'b0;
            gpr_we_reg   <= 1'b0;
            halted_reg   <= 1'b0;
            err_reg      <= 1'b0;
            dec_reg      <= '0;
            inst_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            valid_reg  <= valid_next;
            pc_we_reg  <= (state_next == ST_WB);
            gpr_we_reg <= (state_next == ST_WB) && dec_reg.reg_we && !dec_reg.is_store;
            halted_reg <= (state_next == ST_HALT);
            err_reg    <= (state_next == ST_ERR);
            if ((state_reg == ST_ID) && handshake) begin
                dec_reg <= dec_in;
            end
            if (state_reg == ST_WB) begin
                inst_cnt_reg <= inst_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign bus.ifu_valid_o = valid_reg[STG_IF];
    assign bus.idu_valid_o = valid_reg[STG_ID];
    assign bus.exu_valid_o = valid_reg[STG_EX];
    assign bus.lsu_valid_o = valid_reg[STG_LS];

    assign gpr_we_o   = gpr_we_reg;
    assign pc_we_o    = pc_we_reg;
    assign halted_o   = halted_reg;
    assign err_o      = err_reg;
    assign state_o    = state_reg;
    assign inst_cnt_o = inst_cnt_reg;

endmodule
